mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle main control unit for the MIPS CPU. A Moore state machine decodes the 6-bit opcode latched in the instruction register and sequences every datapath control line, one instruction phase per cycle. Its outputs include the operand-select lines ALUSrcA/ALUSrcB consumed by the ALU operand multiplexer. It also reports illegal opcodes and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- Op  input  6  opcode field of IR (IR[31:26]), stable from DECODE onward
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by ALU Zero (datapath ANDs)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR
- IRWrite  output  1  IR load
- RegDst  output  1  dest register: 0 = rt, 1 = rd
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 = PC, 1 = Rdata1
- ALUSrcB  output  2  00 = Rdata2, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- State  output  4  current state encoding (debug)
- IllegalOp  output  1  one-cycle pulse, registered
- InstrDone  output  1  high in last state of every legal instruction
- RetiredCnt  output  CNT_W  count of completed legal instructions

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, INIT=12. Codes 13–15 are illegal and go to FETCH on the next edge with all outputs 0.
- Outputs are pure functions of state. Every line not listed for a state is 0.
- INIT: all outputs 0. Next state: FETCH.
- FETCH: MemRead, IRWrite, PCWrite; IorD=0; ALUSrcA=0; ALUSrcB=01; ALUOp=00; PCSource=00. Next state: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXEC
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDIEX
  - any other opcode → FETCH, with IllegalOp set
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: MEMRD if Op=lw, else MEMWR.
- MEMRD: MemRead, IorD=1. Next state: MEMWB.
- MEMWB: RegWrite, MemtoReg=1, RegDst=0, InstrDone. Next state: FETCH.
- MEMWR: MemWrite, IorD=1, InstrDone. Next state: FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state: RWB.
- RWB: RegWrite, RegDst=1, MemtoReg=0, InstrDone. Next state: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01, InstrDone. Next state: FETCH.
- JUMP: PCWrite, PCSource=10, InstrDone. Next state: FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: ADDIWB.
- ADDIWB: RegWrite, RegDst=0, MemtoReg=0, InstrDone. Next state: FETCH.
- IllegalOp: registered. It is set on the edge leaving DECODE with an unsupported Op, so it is high for exactly the following FETCH cycle, then cleared.
- RetiredCnt: increments by 1 on each rising edge where InstrDone=1. Wraps from 2^CNT_W−1 to 0. Illegal opcodes are not counted.

## Timing
- Reset (rst_n low, asynchronous): State=INIT, IllegalOp=0, RetiredCnt=0, every control output 0 immediately, without waiting for a clock edge.
- After rst_n rises: the first edge enters FETCH; the second edge enters DECODE.
- Cycles per instruction, counted from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Op is sampled only in DECODE and MEMADR. Changes to Op in any other state have no effect.
- Reset asserted mid-instruction: outputs go to 0 in the same cycle and the in-flight instruction is abandoned. RetiredCnt is not incremented even if reset falls in a cycle where InstrDone=1.
- No two of MemRead, MemWrite, RegWrite are ever high in the same state. IRWrite is high only in FETCH.

## Test plan
- Reset release with Op=000000 → State sequence INIT, FETCH, DECODE, EXEC, RWB, FETCH. RWB drives RegWrite=1, RegDst=1. RetiredCnt=1 after the RWB edge.
- lw (Op=100011) → 5 cycles: FETCH, DECODE, MEMADR, MEMRD, MEMWB. MEMADR shows ALUSrcA=1, ALUSrcB=10. MEMWB shows MemtoReg=1. sw (101011) → MEMWR with MemWrite=1, IorD=1, 4 cycles.
- beq (000100) → BRANCH shows ALUOp=01, PCWriteCond=1, PCSource=01. j (000010) → JUMP shows PCWrite=1, PCSource=10. Both return to FETCH after 3 cycles.
- Op=111111 in DECODE → next state FETCH; IllegalOp=1 for exactly one cycle; RetiredCnt unchanged.
- rst_n pulsed low during MEMRD → all outputs 0 within the same cycle, State=INIT, RetiredCnt=0. Restart proceeds from INIT to FETCH.
- CNT_W=4: run 16 addi instructions (Op=001000) → RetiredCnt reads 15 after the 15th, wraps to 0 after the 16th. Each ADDIEX shows ALUSrcB=10.

Source files
------------

// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module  : mc_control_fsm
// Brief   : Multi-cycle MIPS main control unit. This is a Moore FSM with
//           registered control outputs, illegal-opcode detection and a
//           retired-instruction counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Op,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       State,
    output logic             IllegalOp,
    output logic             InstrDone,
    output logic [CNT_W-1:0] RetiredCnt
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        INIT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    state_t state;
    state_t next_state;
    logic   illegal_next;
    ctrl_t  ctrl;

    // Control word for a given state. Every field that a state does not name stays 0.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
            end
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            MEMWR: begin
                c.mem_write  = 1'b1;
                c.iord       = 1'b1;
                c.instr_done = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            RWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.instr_done    = 1'b1;
            end
            JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = 2'b10;
                c.instr_done = 1'b1;
            end
            ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDIWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        next_state   = FETCH;
        illegal_next = 1'b0;
        case (state)
            INIT:   next_state = FETCH;
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXEC;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = ADDIEX;
                    default: begin
                        next_state   = FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            MEMADR: next_state = (Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  next_state = MEMWB;
            EXEC:   next_state = RWB;
            ADDIEX: next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    // Outputs are registered from the next state, so they always describe the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            ctrl       <= '0;
            IllegalOp  <= 1'b0;
            RetiredCnt <= '0;
        end else begin
            state     <= next_state;
            ctrl      <= ctrl_for(next_state);
            IllegalOp <= illegal_next;
            if (ctrl.instr_done) begin
                RetiredCnt <= RetiredCnt + CNT_ONE;
            end
        end
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign InstrDone   = ctrl.instr_done;
    assign State       = state;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// Directed, table-driven bench for mc_control_fsm (CNT_W=4 so counter wrap is reachable).
`default_nettype none

module tb_mc_control_fsm;

    localparam int CW = 4;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_INIT   = 4'd12;

    localparam logic [5:0] R   = 6'b000000;
    localparam logic [5:0] J   = 6'b000010;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] ADI = 6'b001000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] ILL = 6'b111111;

    logic          clk;
    logic          rst_n;
    logic [5:0]    Op;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic          IRWrite, RegDst, RegWrite, ALUSrcA;
    logic [1:0]    ALUSrcB, ALUOp, PCSource;
    logic [3:0]    State;
    logic          IllegalOp, InstrDone;
    logic [CW-1:0] RetiredCnt;

    mc_control_fsm #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .State(State), .IllegalOp(IllegalOp),
        .InstrDone(InstrDone), .RetiredCnt(RetiredCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,InstrDone}
    logic [16:0] dut_ctrl;
    assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                       RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone};

    function automatic logic [16:0] spec_ctrl(input logic [3:0] st);
        logic [16:0] c;
        c = '0;
        case (st)
            S_FETCH:  begin c[16] = 1'b1; c[13] = 1'b1; c[10] = 1'b1; c[6:5] = 2'b01; end
            S_DECODE: begin c[6:5] = 2'b11; end
            S_MEMADR: begin c[7] = 1'b1; c[6:5] = 2'b10; end
            S_MEMRD:  begin c[13] = 1'b1; c[14] = 1'b1; end
            S_MEMWB:  begin c[8] = 1'b1; c[11] = 1'b1; c[0] = 1'b1; end
            S_MEMWR:  begin c[12] = 1'b1; c[14] = 1'b1; c[0] = 1'b1; end
            S_EXEC:   begin c[7] = 1'b1; c[4:3] = 2'b10; end
            S_RWB:    begin c[8] = 1'b1; c[9] = 1'b1; c[0] = 1'b1; end
            S_BRANCH: begin c[7] = 1'b1; c[4:3] = 2'b01; c[15] = 1'b1; c[2:1] = 2'b01; c[0] = 1'b1; end
            S_JUMP:   begin c[16] = 1'b1; c[2:1] = 2'b10; c[0] = 1'b1; end
            S_ADDIEX: begin c[7] = 1'b1; c[6:5] = 2'b10; end
            S_ADDIWB: begin c[8] = 1'b1; c[0] = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    typedef struct {
        logic [5:0]    op;
        logic [3:0]    st;
        logic          ill;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [5:0] op, input logic [3:0] st, input logic ill, input int cnt);
        vec_t v;
        v.op  = op;
        v.st  = st;
        v.ill = ill;
        v.cnt = CW'(cnt);
        tbl.push_back(v);
    endtask

    initial begin
        // Each row: Op driven during the cycle, then expected state/flags/count after the edge.
        add(R,   S_FETCH,  0, 0); add(R,   S_DECODE, 0, 0); add(R,   S_EXEC,   0, 0);
        add(R,   S_RWB,    0, 0); add(LW,  S_FETCH,  0, 1);
        add(LW,  S_DECODE, 0, 1); add(LW,  S_MEMADR, 0, 1); add(LW,  S_MEMRD,  0, 1);
        add(LW,  S_MEMWB,  0, 1); add(SW,  S_FETCH,  0, 2);
        add(SW,  S_DECODE, 0, 2); add(SW,  S_MEMADR, 0, 2); add(SW,  S_MEMWR,  0, 2);
        add(BEQ, S_FETCH,  0, 3);
        add(BEQ, S_DECODE, 0, 3); add(BEQ, S_BRANCH, 0, 3); add(J,   S_FETCH,  0, 4);
        add(J,   S_DECODE, 0, 4); add(J,   S_JUMP,   0, 4); add(ADI, S_FETCH,  0, 5);
        add(ADI, S_DECODE, 0, 5); add(ADI, S_ADDIEX, 0, 5); add(ADI, S_ADDIWB, 0, 5);
        add(ILL, S_FETCH,  0, 6);
        add(ILL, S_DECODE, 0, 6); add(ILL, S_FETCH,  1, 6); add(R,   S_DECODE, 0, 6);
        add(R,   S_EXEC,   0, 6); add(ILL, S_RWB,    0, 6); add(SW,  S_FETCH,  0, 7);
        add(J,   S_DECODE, 0, 7); add(J,   S_JUMP,   0, 7); add(LW,  S_FETCH,  0, 8);

        Op    = R;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_state", 32'(State), 32'(S_INIT));
        chk("reset_ctrl",  32'(dut_ctrl), 32'd0);
        chk("reset_ill",   32'(IllegalOp), 32'd0);
        chk("reset_cnt",   32'(RetiredCnt), 32'd0);
        step();
        chk("reset_hold_state", 32'(State), 32'(S_INIT));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            Op = tbl[i].op;
            step();
            chk($sformatf("row%0d_state", i), 32'(State), 32'(tbl[i].st));
            chk($sformatf("row%0d_ctrl",  i), 32'(dut_ctrl), 32'(spec_ctrl(tbl[i].st)));
            chk($sformatf("row%0d_ill",   i), 32'(IllegalOp), 32'(tbl[i].ill));
            chk($sformatf("row%0d_cnt",   i), 32'(RetiredCnt), 32'(tbl[i].cnt));
        end

        // Asynchronous reset in the middle of a lw, while sitting in MEMRD.
        Op = LW;
        step(); step(); step();
        chk("pre_rst_state",   32'(State), 32'(S_MEMRD));
        chk("pre_rst_memread", 32'(MemRead), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_state", 32'(State), 32'(S_INIT));
        chk("midrst_ctrl",  32'(dut_ctrl), 32'd0);
        chk("midrst_cnt",   32'(RetiredCnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("restart_fetch", 32'(State), 32'(S_FETCH));
        chk("restart_irw",   32'(IRWrite), 32'd1);

        // Sixteen addi instructions: counter reaches 15 and then wraps to 0.
        Op = ADI;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("addi_decode", 32'(State), 32'(S_DECODE));
            step();
            chk("addi_ex_state", 32'(State), 32'(S_ADDIEX));
            chk("addi_ex_srcb",  32'(ALUSrcB), 32'd2);
            step();
            chk("addi_wb_state", 32'(State), 32'(S_ADDIWB));
            step();
            chk($sformatf("addi%0d_cnt", k), 32'(RetiredCnt), 32'(k % 16));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
